// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, a DEPTH-slot return ring and valid/ready issue to decode.
// A redirect flushes the ring; old-path responses still in flight are counted and dropped as discards.

module fetch_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc,
  input  logic        fill,
  input  logic        pop,
  input  logic [31:0] alloc_pc,
  input  logic [31:0] fill_data,
  output logic [31:0] pc,
  output logic [31:0] data,
  output logic        filled
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      data   <= '0;
      filled <= 1'b0;
    end else if (flush) begin
      filled <= 1'b0;
    end else begin
      if (alloc) begin
        pc     <= alloc_pc;
        filled <= 1'b0;
      end
      if (fill) begin
        data   <= fill_data;
        filled <= 1'b1;
      end
      if (pop) filled <= 1'b0;
    end
  end
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7
);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]            fetch_pc;
  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [CW-1:0]          alloc_ptr, fill_ptr, head_ptr, discard;
  logic [CW-1:0]          count, unfilled, redir_discard;
  logic [CW:0]            occupancy;
  logic [PW-1:0]          alloc_idx, fill_idx, head_idx;
  logic                   grant, resp_drop, resp_fill, pop, redir_drop;
  logic [DEPTH-1:0][31:0] slot_pc, slot_data;
  logic [DEPTH-1:0]       slot_filled;

  assign count     = alloc_ptr - head_ptr;
  assign unfilled  = alloc_ptr - fill_ptr;
  assign occupancy = {1'b0, count} + {1'b0, discard};
  assign alloc_idx = alloc_ptr[PW-1:0];
  assign fill_idx  = fill_ptr[PW-1:0];
  assign head_idx  = head_ptr[PW-1:0];

  assign imem_req  = rst_n & ~redirect & (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;

  // Unsolicited responses (no discard pending, nothing outstanding) fall through both terms.
  assign resp_drop = imem_rvalid & (discard != '0);
  assign resp_fill = imem_rvalid & (discard == '0) & (unfilled != '0) & ~redirect;

  // In the redirect cycle the arriving word is charged to a discard or an old-path slot.
  assign redir_drop    = imem_rvalid & ((discard != '0) | (unfilled != '0));
  assign redir_discard = discard + unfilled - (redir_drop ? ONE : '0);

  assign instr_valid = slot_filled[head_idx] & (count != '0);
  assign pop         = instr_valid & instr_ready & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      discard   <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc & ~32'h3;
      fill_ptr  <= alloc_ptr;
      head_ptr  <= alloc_ptr;
      discard   <= redir_discard;
    end else begin
      if (grant) begin
        alloc_ptr <= alloc_ptr + ONE;
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (resp_drop) discard  <= discard - ONE;
      if (resp_fill) fill_ptr <= fill_ptr + ONE;
      if (pop)       head_ptr <= head_ptr + ONE;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    fetch_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .alloc     (grant && (alloc_idx == PW'(i))),
      .fill      (resp_fill && (fill_idx == PW'(i))),
      .pop       (pop && (head_idx == PW'(i))),
      .alloc_pc  (fetch_pc),
      .fill_data (imem_rdata),
      .pc        (slot_pc[i]),
      .data      (slot_data[i]),
      .filled    (slot_filled[i])
    );
  end

  always_comb begin
    instr    = NOP;
    instr_pc = '0;
    if (instr_valid) begin
      instr    = slot_data[head_idx];
      instr_pc = slot_pc[head_idx];
    end
  end

  assign instr_pc4 = instr_pc + 32'd4;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle, an in-order memory
// responder with configurable latency, and directed phases pinned by literal expectations.

module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid, instr_ready = 1'b0, funct7;
  logic [31:0] instr, instr_pc, instr_pc4;
  logic [6:0]  op;
  logic [2:0]  funct3;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
    .op(op), .funct3(funct3), .funct7(funct7)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } ent_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fpc = RESET_PC;
  int          m_disc = 0;
  int          cyc = 0, lat = 1, last_due = 0, r0 = 0;
  int          checks = 0, errors = 0, gnt_cnt = 0;
  logic [31:0] pop_pc[$], pop_pc4[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] qpc(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] qpc4(input int i);
    return (i < pop_pc4.size()) ? pop_pc4[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] qcyc(input int i);
    return (i < pop_cyc.size()) ? pop_cyc[i] - r0 : 32'hxxxx_xxxx;
  endfunction

  // Reference model and compare: outputs are meaningful every cycle, including reset.
  bit          e_req, e_valid, m_grant;
  int          unf;
  logic [31:0] e_instr, e_pc;
  ent_t        t;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      mq.delete(); memq.delete();
      m_fpc = RESET_PC; m_disc = 0; last_due = 0;
    end
    e_req   = (rst_n === 1'b1) && !redirect && (mq.size() + m_disc < DEPTH);
    e_valid = (mq.size() > 0) && mq[0].filled;
    e_instr = e_valid ? mq[0].data : 32'h0000_0013;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    chk("imem_addr", imem_addr, m_fpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
    chk("instr", instr, e_instr);
    chk("instr_pc", instr_pc, e_pc);
    chk("instr_pc4", instr_pc4, e_pc + 32'd4);
    chk("op", {25'b0, op}, {25'b0, e_instr[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, e_instr[14:12]});
    chk("funct7", {31'b0, funct7}, {31'b0, e_instr[30]});
    if (instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc); pop_pc4.push_back(instr_pc4); pop_cyc.push_back(cyc);
    end
    if (rst_n === 1'b1) begin
      m_grant = e_req && imem_gnt;
      if (redirect) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        m_disc = m_disc + unf - ((imem_rvalid && (m_disc > 0 || unf > 0)) ? 1 : 0);
        mq.delete();
        m_fpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (imem_rvalid) begin
          if (m_disc > 0) m_disc--;
          else
            for (int i = 0; i < mq.size(); i++)
              if (!mq[i].filled) begin
                t = mq[i]; t.data = imem_rdata; t.filled = 1'b1; mq[i] = t;
                break;
              end
        end
        if (e_valid && instr_ready) void'(mq.pop_front());
        if (m_grant) begin
          t.pc = m_fpc; t.data = 32'h0; t.filled = 1'b0;
          mq.push_back(t);
          m_fpc = m_fpc + 32'd4;
        end
      end
      // The memory reacts to what the DUT actually presented.
      if (imem_req && imem_gnt) begin
        mreq_t r;
        r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.addr = imem_addr;
        last_due = r.due;
        memq.push_back(r);
        gnt_cnt++;
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_pc.delete(); pop_pc4.delete(); pop_cyc.delete(); gnt_cnt = 0; r0 = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  logic [31:0] gpat = 32'hB5D3_6E9A, rpat = 32'h9F3C_A6D5;

  initial begin
    // Reset and stream
    lat = 1; imem_gnt = 1'b1; instr_ready = 1'b1;
    do_reset();
    #1;
    chk("rst_first_req", {31'b0, imem_req}, 32'd1);
    chk("rst_first_addr", imem_addr, 32'h100);
    tick(10);
    chk("st_pc0", qpc(0), 32'h100);
    chk("st_pc1", qpc(1), 32'h104);
    chk("st_pc2", qpc(2), 32'h108);
    chk("st_pc3", qpc(3), 32'h10C);
    chk("st_pc4_0", qpc4(0), 32'h104);
    chk("st_lat", qcyc(0), 32'd2);
    chk("st_rate", qcyc(3), 32'd5);

    // Backpressure
    instr_ready = 1'b0;
    do_reset();
    tick(6);
    chk("bp_grants", gnt_cnt, 32'd4);
    chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    chk("bp_head", instr_pc, 32'h100);
    instr_ready = 1'b1;
    clear_logs();
    tick(8);
    chk("bp_pc0", qpc(0), 32'h100);
    chk("bp_pc1", qpc(1), 32'h104);
    chk("bp_pc2", qpc(2), 32'h108);
    chk("bp_pc3", qpc(3), 32'h10C);
    chk("bp_gap", qcyc(3) - qcyc(0), 32'd3);

    // Redirect with two unfilled requests, 3-cycle memory
    lat = 3;
    do_reset();
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    #1;
    chk("rd_req", {31'b0, imem_req}, 32'd1);
    chk("rd_addr", imem_addr, 32'h200);
    tick(10);
    chk("rd_pc0", qpc(0), 32'h200);
    chk("rd_pc1", qpc(1), 32'h204);

    // Redirect concurrent with pop and rvalid
    lat = 1;
    do_reset();
    tick(4);
    redirect = 1'b1; redirect_pc = 32'h300;
    clear_logs();
    tick(1);
    redirect = 1'b0;
    tick(6);
    chk("rc_popped", qpc(0), 32'h108);
    chk("rc_new", qpc(1), 32'h300);
    chk("rc_gap", qcyc(1), 32'd3);

    // Wrap-around
    do_reset();
    tick(3);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick(6);
    chk("wr_pc0", qpc(0), 32'hFFFF_FFFC);
    chk("wr_pc4_0", qpc4(0), 32'h0);
    chk("wr_pc1", qpc(1), 32'h0);

    // Async reset between clock edges
    do_reset();
    tick(5);
    chk("ar_pre_valid", {31'b0, instr_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_addr", imem_addr, RESET_PC);
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    #1;
    chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
    chk("ar_restart_addr", imem_addr, RESET_PC);
    tick(6);
    chk("ar_pc0", qpc(0), RESET_PC);
    chk("ar_lat", qcyc(0), 32'd2);

    // Mixed grant/ready patterns with redirects, 2-cycle memory
    lat = 2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      imem_gnt    = gpat[i % 32];
      instr_ready = rpat[i % 32];
      redirect    = (i == 13) || (i == 27);
      redirect_pc = (i == 13) ? 32'h480 : 32'h5A6;
      tick(1);
    end
    redirect = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode/controller logic. It holds the fetch PC, issues in-order requests to instruction memory over a request/grant and response handshake, and buffers returned words with their PCs in a small ring. It presents one instruction per cycle to decode over a valid/ready handshake, and flushes itself when the controller's PC-select (`PCsrc`) redirects the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, buffer slots and maximum outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals fetch_pc.
- imem_gnt  in  1  request accepted in this cycle when imem_req=1.
- imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- redirect  in  1  taken branch or jump; driven by the controller's PCsrc.
- redirect_pc  in  32  new fetch target.
- instr_valid  out  1  head instruction available.
- instr_ready  in  1  decode accepts the head instruction.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- instr_pc4  out  32  instr_pc + 4, modulo 2^32.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].

## Operation
- **State**
  - fetch_pc (32 bits).
  - Ring of DEPTH slots, each holding {pc, data, filled}.
  - Pointers: alloc, fill and head.
  - count: slots allocated and not yet popped.
  - discard counter, width clog2(DEPTH)+1.
- **Request**
  - imem_req = (count + discard < DEPTH) & ~redirect.
- **Grant** (imem_req & imem_gnt)
  - Allocate the slot at alloc with pc = fetch_pc and filled = 0.
  - alloc++, count++, fetch_pc += 4 (wraps at 2^32).
- **Response** (imem_rvalid)
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: write data into the slot at fill, set filled = 1, fill++.
  - An rvalid with no outstanding request is ignored.
- **Output**
  - instr_valid = slot[head].filled & (count > 0).
  - Pop on instr_valid & instr_ready: clear filled, head++, count--.
  - When instr_valid = 0: instr = 32'h0000_0013 (NOP), instr_pc = 0, and op/funct3/funct7 are decoded from the NOP.
- **Redirect** (takes priority over grant, pop and fill in the same cycle)
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - All slots are invalidated; count = 0 and the pointers are equalised.
  - discard_next = discard + (allocated-but-unfilled slots) − (1 if imem_rvalid is dropped this cycle, else 0).
  - An rvalid in the redirect cycle is always dropped; it consumes an old-path slot or a discard.
- **Allocation with a concurrent pop**
  - Allocation in a cycle with a concurrent pop uses the pre-pop count. There is no same-cycle slot reuse.

## Timing
- **Reset values**
  - imem_req = 0 while rst_n is low; imem_addr = RESET_PC.
  - instr_valid = 0, count = 0, discard = 0, fetch_pc = RESET_PC.
  - In the first cycle after rst_n rises, imem_req = 1 with imem_addr = RESET_PC.
- **Latency**
  - Grant in cycle N, rvalid in cycle N+1, instr_valid in cycle N+2. Fill is registered; there is no combinational bypass from imem_rdata to instr.
- **Throughput**
  - With DEPTH = 4 and single-cycle memory, one instruction per cycle is sustained.
  - With DEPTH = 2, the rate drops to 2 instructions per 3 cycles.
- **Output stability**
  - While instr_valid & ~instr_ready, all outputs are held stable.
- **After redirect**
  - imem_req is 0 in the redirect cycle and rises in the next cycle with imem_addr = redirect target.
  - instr_valid = 0 until the first new-path word is filled.
- **Full buffer**
  - count + discard = DEPTH ⇒ imem_req = 0. Requests resume in the cycle after a pop or a discarded response.
- **Reset mid-operation**
  - All state is cleared immediately. Responses arriving after reset release are treated as unsolicited and ignored; the memory must be reset together with this block.

## Test plan
- **Reset and stream**
  - Stimulus: RESET_PC = 0x100, gnt tied to 1, 1-cycle memory, ready = 1.
  - Required: instr_pc sequence 0x100, 0x104, 0x108… with one instruction per cycle from cycle 3; instr_pc4 = instr_pc + 4.
- **Backpressure**
  - Stimulus: ready = 0 for 6 cycles.
  - Required: imem_req falls after 4 grants; the head holds pc 0x100 unchanged; releasing ready yields 0x100..0x10C in order with no gap or duplicate.
- **Redirect with outstanding requests**
  - Stimulus: 3-cycle memory latency, redirect to 0x203 while 2 requests are unfilled.
  - Required: next imem_addr = 0x200; the 2 old responses are dropped; the first instr_pc after the redirect is 0x200.
- **Redirect concurrent with pop and rvalid**
  - Required: the popped instruction is not re-presented; the rvalid word is discarded; no stale PC reaches the output.
- **Wrap-around**
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: fetches 0xFFFF_FFFC then 0x0000_0000; instr_pc4 of the first instruction = 0.
- **Async reset mid-stream**
  - Stimulus: drop rst_n between clock edges.
  - Required: instr_valid and imem_req go low without waiting for a clock edge; fetch restarts at RESET_PC after release.
